quad_enc_tx: RTL and testbench
==============================

QUAD_ENC_TX -- requirements
Module: quad_enc_tx

Interface
REQ-001 SHALL have parameter CNTBITS, default 32, width of signed position counter.
REQ-002 SHALL have parameter DIVBITS, default 16, width of edge-spacing timer and period config.
REQ-003 SHALL have parameter CPRBITS, default 16, width of counts-per-revolution config.
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  high = accept steps; low = ready forced low, outputs hold.
REQ-007 SHALL have port step_valid  input  1  step request.
REQ-008 SHALL have port step_dir  input  1  1 = forward (count up), 0 = reverse; sampled with step_valid.
REQ-009 SHALL have port step_ready  output  1  request accepted when valid and ready are both high.
REQ-010 SHALL have port config_min_period  input  DIVBITS  minimum CLK cycles between successive A/B edges.
REQ-011 SHALL have port config_cpr  input  CPRBITS  quadrature counts per revolution; 0 disables index.
REQ-012 SHALL have port enc_a, enc_b  output  1 each  registered quadrature phases.
REQ-013 SHALL have port enc_index  output  1  registered index, high while revolution position is 0.
REQ-014 SHALL have port count  output  CNTBITS signed  total emitted position.

Function
REQ-015 SHALL use the forward Gray sequence AB = 00 -> 10 -> 11 -> 01 -> 00 (A leads B); reverse SHALL traverse it backwards.
REQ-016 SHALL advance exactly one Gray state per accepted request; enc_a/enc_b change in the cycle after acceptance (latency 1), and exactly one of them toggles.
REQ-017 SHALL update count (+1 forward, -1 reverse) in the same cycle as the A/B change; count wraps two's complement without saturation.
REQ-018 SHALL implement FSM states IDLE and HOLD: IDLE with enable high drives step_ready high; acceptance moves to HOLD and loads timer with max(config_min_period,1)-1.
REQ-019 In HOLD, step_ready SHALL be low; timer SHALL decrement each cycle; transition to IDLE occurs on the cycle after timer reaches 0, giving accept-to-accept spacing of exactly max(config_min_period,1) cycles.
REQ-020 config_min_period SHALL be sampled only at acceptance; changes during HOLD do not affect the current hold.
REQ-021 step_ready SHALL be combinational from state and enable only (not from step_valid).
REQ-022 enable low SHALL force step_ready low in any state; HOLD timer keeps running; A/B, count, index hold.
REQ-023 SHALL keep rev_pos in range 0..config_cpr-1: forward wraps cpr-1 -> 0, reverse wraps 0 -> cpr-1; enc_index registered = (rev_pos == 0) and config_cpr != 0.
REQ-024 If config_cpr changes such that rev_pos >= config_cpr, the next forward step SHALL wrap rev_pos to 0 and next reverse step SHALL load config_cpr-1.
REQ-025 config_cpr == 0 SHALL hold rev_pos at 0 and enc_index low.
REQ-026 step_dir reversal between consecutive accepts SHALL produce a single toggle back to the prior Gray state (no skipped states, no glitch).

Reset
REQ-027 On resetn low, asynchronously: enc_a=0, enc_b=0, count=0, rev_pos=0, timer=0, state=IDLE, step_ready=0, enc_index=0.
REQ-028 After resetn deasserts, enc_index SHALL become 1 on the first clock if config_cpr != 0; step_ready high per REQ-018.
REQ-029 Reset asserted during HOLD SHALL abort the hold; a request present at reset release SHALL be accepted no earlier than the first clock edge after release.

Verification
REQ-030 Period=4, dir=1, valid held high, 8 accepts -> AB 10,11,01,00,10,11,01,00; accepts spaced 4 cycles; count=8.
REQ-031 Period=0 and period=1, valid held -> accept every cycle, AB changes every cycle, one bit per change.
REQ-032 cpr=4, 5 reverse steps from reset -> count=-5, rev_pos 3,2,1,0,3; enc_index high only after step 4.
REQ-033 count preset via 2^31-1 forward steps (CNTBITS=32, or reduced CNTBITS=4 with 7 steps) then one more -> count wraps to most-negative value.
REQ-034 enable dropped mid-HOLD with valid high -> no accept while low; accept occurs first cycle enable returns high after timer expiry.
REQ-035 resetn pulsed low mid-HOLD at count=3 -> all outputs zero immediately, no edge emitted during reset, next accept yields AB=10, count=1.

Source files
------------

// File: rtl/quad_enc_tx.sv
// Quadrature encoder emulator: turns accepted step requests into A/B/index phases,
// spaced at least config_min_period clocks apart, with a signed position count.
//
// state | meaning
// IDLE  | ready for a step whenever enable is high
// HOLD  | enforcing minimum edge spacing; timer counts down to the next IDLE
module quad_enc_tx #(
  parameter int CNTBITS = 32,
  parameter int DIVBITS = 16,
  parameter int CPRBITS = 16
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic                      step_valid,
  input  logic                      step_dir,
  output logic                      step_ready,
  input  logic [DIVBITS-1:0]        config_min_period,
  input  logic [CPRBITS-1:0]        config_cpr,
  output logic                      enc_a,
  output logic                      enc_b,
  output logic                      enc_index,
  output logic signed [CNTBITS-1:0] count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [DIVBITS-1:0]        ONE_D = DIVBITS'(1);
  localparam logic [CPRBITS-1:0]        ONE_C = CPRBITS'(1);
  localparam logic signed [CNTBITS-1:0] ONE_N = CNTBITS'(1);

  logic [0:0]         state;
  logic [DIVBITS-1:0] timer;
  logic [DIVBITS-1:0] hold_len;
  logic [CPRBITS-1:0] rev_pos;
  logic [CPRBITS-1:0] rev_pos_nxt;
  logic               accept;
  logic               toggle_a;

  assign step_ready = resetn & enable & (state == IDLE);
  assign accept     = step_valid & step_ready;
  assign hold_len   = (config_min_period == '0) ? '0 : config_min_period - ONE_D;

  // Forward toggles A when A==B, else B; reverse is the mirror image.
  assign toggle_a   = ((enc_a ~^ enc_b) == step_dir);

  // Out-of-range positions (after a cpr shrink) snap to 0 going forward, cpr-1 going back.
  always_comb begin
    rev_pos_nxt = rev_pos;
    if (config_cpr == '0) begin
      rev_pos_nxt = '0;
    end else if (accept) begin
      if (step_dir) begin
        rev_pos_nxt = (rev_pos >= config_cpr - ONE_C) ? '0 : rev_pos + ONE_C;
      end else begin
        rev_pos_nxt = ((rev_pos == '0) || (rev_pos >= config_cpr)) ?
                      config_cpr - ONE_C : rev_pos - ONE_C;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      timer     <= '0;
      rev_pos   <= '0;
      enc_a     <= 1'b0;
      enc_b     <= 1'b0;
      enc_index <= 1'b0;
      count     <= '0;
    end else begin
      rev_pos   <= rev_pos_nxt;
      enc_index <= (config_cpr != '0) && (rev_pos_nxt == '0);

      // A one-cycle spacing needs no hold at all, so stay in IDLE.
      case (state)
        IDLE: begin
          if (accept) begin
            timer <= hold_len;
            if (hold_len != '0) state <= HOLD;
          end
        end
        HOLD: begin
          if (timer != '0) timer <= timer - ONE_D;
          if (timer <= ONE_D) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase

      if (accept) begin
        if (toggle_a) enc_a <= ~enc_a;
        else          enc_b <= ~enc_b;
        count <= step_dir ? count + ONE_N : count - ONE_N;
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_tx.sv
// Bench for quad_enc_tx: directed table, corner-case sequences and a random run
// against a cycle-level reference model of the step/spacing/position rules.
module tb_quad_enc_tx;
  localparam int CNTBITS = 8;
  localparam int DIVBITS = 8;
  localparam int CPRBITS = 8;

  logic                      CLK = 1'b0;
  logic                      resetn = 1'b0;
  logic                      enable = 1'b0;
  logic                      step_valid = 1'b0;
  logic                      step_dir = 1'b0;
  logic                      step_ready;
  logic [DIVBITS-1:0]        config_min_period = '0;
  logic [CPRBITS-1:0]        config_cpr = '0;
  logic                      enc_a;
  logic                      enc_b;
  logic                      enc_index;
  logic signed [CNTBITS-1:0] count;

  quad_enc_tx #(.CNTBITS(CNTBITS), .DIVBITS(DIVBITS), .CPRBITS(CPRBITS)) dut (
    .CLK(CLK), .resetn(resetn), .enable(enable), .step_valid(step_valid),
    .step_dir(step_dir), .step_ready(step_ready),
    .config_min_period(config_min_period), .config_cpr(config_cpr),
    .enc_a(enc_a), .enc_b(enc_b), .enc_index(enc_index), .count(count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase index into the Gray cycle, integer position,
  // and the earliest edge number at which another step may be taken.
  int m_phase, m_count, m_rev, m_cyc, m_next;
  bit m_idx;
  bit last_acc;

  typedef struct {
    bit       dir;
    bit [1:0] ab;
    int       cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] ab_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int wrap_cnt(input int v);
    int r;
    r = ((v % 256) + 256) % 256;
    if (r >= 128) r -= 256;
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_rev = 0; m_idx = 0; m_cyc = 0; m_next = 0;
  endtask

  task automatic set_in(input bit en, input bit vld, input bit dir, input int per, input int cpr);
    enable = en; step_valid = vld; step_dir = dir;
    config_min_period = DIVBITS'(per); config_cpr = CPRBITS'(cpr);
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic tick();
    bit exp_rdy, acc;
    int p, cpr;
    @(negedge CLK);
    exp_rdy = enable && (m_cyc >= m_next);
    check("ready", step_ready, exp_rdy);
    acc = step_valid && exp_rdy;
    p   = int'(config_min_period);
    cpr = int'(config_cpr);
    @(posedge CLK);
    if (acc) begin
      if (step_dir) begin
        m_phase = (m_phase + 1) % 4;
        m_count = wrap_cnt(m_count + 1);
        if (cpr != 0) m_rev = (m_rev + 1 >= cpr) ? 0 : m_rev + 1;
      end else begin
        m_phase = (m_phase + 3) % 4;
        m_count = wrap_cnt(m_count - 1);
        if (cpr != 0) m_rev = (m_rev == 0 || m_rev >= cpr) ? cpr - 1 : m_rev - 1;
      end
      m_next = m_cyc + ((p < 1) ? 1 : p);
    end
    if (cpr == 0) m_rev = 0;
    m_idx = (cpr != 0) && (m_rev == 0);
    m_cyc++;
    last_acc = acc;
    #1;
    check("ab", {enc_a, enc_b}, ab_of(m_phase));
    check("count", count, m_count);
    check("index", enc_index, m_idx);
  endtask

  // Asserts reset mid-cycle, checks the async clear, releases just after an edge.
  task automatic apply_reset();
    #3 resetn = 1'b0;
    #1;
    check("rst_ab", {enc_a, enc_b}, 0);
    check("rst_count", count, 0);
    check("rst_index", enc_index, 0);
    check("rst_ready", step_ready, 0);
    repeat (2) begin
      @(posedge CLK); #1;
      check("rst_hold_ab", {enc_a, enc_b}, 0);
      check("rst_hold_count", count, 0);
    end
    @(posedge CLK); #1 resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int chg[$];
    bit [1:0] seq[$];
    bit [1:0] prev;
    bit exp_idx[5];

    tbl[0] = '{1'b1, 2'b10,  1};
    tbl[1] = '{1'b1, 2'b11,  2};
    tbl[2] = '{1'b1, 2'b01,  3};
    tbl[3] = '{1'b0, 2'b11,  2};
    tbl[4] = '{1'b0, 2'b10,  1};
    tbl[5] = '{1'b0, 2'b00,  0};
    tbl[6] = '{1'b0, 2'b01, -1};
    tbl[7] = '{1'b1, 2'b00,  0};

    #1;
    check("por_ab", {enc_a, enc_b}, 0);
    check("por_ready", step_ready, 0);

    // Directed table, back-to-back steps including direction reversals
    apply_reset();
    set_in(1, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step_dir = tbl[i].dir;
      tick();
      check("tbl_ab", {enc_a, enc_b}, tbl[i].ab);
      check("tbl_count", count, tbl[i].cnt);
    end

    // Period 4, eight forward steps
    apply_reset();
    set_in(1, 1, 1, 4, 0);
    prev = 2'b00;
    for (int c = 0; c < 29; c++) begin
      tick();
      if ({enc_a, enc_b} != prev) begin
        chg.push_back(c);
        seq.push_back({enc_a, enc_b});
        prev = {enc_a, enc_b};
      end
    end
    check("p4_edges", chg.size(), 8);
    for (int i = 0; i < chg.size(); i++) begin
      check("p4_seq", seq[i], ab_of((i + 1) % 4));
      if (i > 0) check("p4_spacing", chg[i] - chg[i-1], 4);
    end
    check("p4_count", count, 8);

    // Period 0 and 1: a step every clock, one phase bit per step
    for (int per = 0; per < 2; per++) begin
      apply_reset();
      set_in(1, 1, 1, per, 0);
      prev = 2'b00;
      for (int c = 0; c < 6; c++) begin
        tick();
        check("fast_onebit", $countones(prev ^ {enc_a, enc_b}), 1);
        prev = {enc_a, enc_b};
      end
    end

    // cpr=4, five reverse steps
    apply_reset();
    exp_idx = '{0, 0, 0, 1, 0};
    set_in(1, 1, 0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cpr4_index", enc_index, exp_idx[i]);
    end
    check("cpr4_count", count, -5);

    // Count wrap at the positive limit
    apply_reset();
    set_in(1, 1, 1, 0, 0);
    repeat (127) tick();
    check("wrap_max", count, 127);
    tick();
    check("wrap_min", count, -128);

    // Enable dropped during a hold
    apply_reset();
    set_in(1, 1, 1, 6, 0);
    tick();
    enable = 1'b0;
    repeat (8) tick();
    check("en_low_count", count, 1);
    enable = 1'b1;
    tick();
    check("en_back_acc", last_acc, 1);
    check("en_back_count", count, 2);

    // Reset during a hold at count 3
    apply_reset();
    set_in(1, 1, 1, 10, 0);
    repeat (21) tick();
    check("hold_count3", count, 3);
    apply_reset();
    tick();
    check("post_rst_ab", {enc_a, enc_b}, 2'b10);
    check("post_rst_count", count, 1);

    // Random traffic against the model
    apply_reset();
    set_in(1, 1, 1, 2, 5);
    for (int c = 0; c < 1500; c++) begin
      enable     = ($urandom_range(0, 9) < 8);
      step_valid = ($urandom_range(0, 9) < 7);
      step_dir   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) config_min_period = DIVBITS'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) config_cpr = CPRBITS'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) apply_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
